// File: rtl/subleq_core_if.sv
// subleq_core_if
//  RAM port bundle between the SUBLEQ sequencer and its 8x256 1r1w RAM.
//  master (core side) : drives radr, wadr, wdata, wen; receives rdata
//  slave  (RAM side)  : receives radr, wadr, wdata, wen; drives rdata
//  radr   8  read address, sampled by the RAM on posedge
//  rdata  8  read data, valid the cycle after radr was sampled
//  wadr   8  write address
//  wdata  8  write data
//  wen    1  write enable, single-cycle pulse
interface subleq_core_if;
  logic [7:0] radr;
  logic [7:0] rdata;
  logic [7:0] wadr;
  logic [7:0] wdata;
  logic       wen;

  modport master (
    output radr,
    output wadr,
    output wdata,
    output wen,
    input  rdata
  );

  modport slave (
    input  radr,
    input  wadr,
    input  wdata,
    input  wen,
    output rdata
  );
endinterface

// File: rtl/subleq_core.sv
// subleq_core
//  Sequencer/datapath for the SUBLEQ CPU. Executes "SUBLEQ A,B,C":
//  mem[B] <= mem[B]-mem[A]; branch to C when the signed result is <= 0,
//  otherwise advance pc by 3. One instruction takes six cycles (FA..WB).
// Ports
//  clk        in   1      system clock, posedge
//  rst_n      in   1      asynchronous active-low reset
//  start_i    in   1      pulse: from IDLE/HALT load START_PC, clear counter, run
//  stop_i     in   1      level: park in IDLE at the next instruction boundary
//  ram        master      RAM read/write port bundle (subleq_core_if)
//  pc_o       out  8      current instruction address
//  busy_o     out  1      high in any execute state
//  halted_o   out  1      high in HALT
//  inst_cnt_o out  CNT_W  retired instructions since last start, saturating
module subleq_core #(
  parameter logic [7:0]  START_PC = 8'h00,
  parameter logic [7:0]  HALT_ADR = 8'hFF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
  subleq_core_if.master     ram,
  output logic [7:0]        pc_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  inst_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FA, S_FB, S_FC, S_FM, S_FN, S_WB, S_HALT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       c_q, c_d;
  logic [7:0]       ma_q, ma_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // In WB, rdata holds mem[B] (fetched in FN); ma holds mem[A].
  logic [7:0] res;
  logic       taken;
  assign res   = ram.rdata - ma_q;
  assign taken = res[7] | (res == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      c_q     <= 8'h00;
      ma_q    <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      ma_q    <= ma_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    ma_d      = ma_q;
    cnt_d     = cnt_q;
    ram.radr  = pc_q;
    ram.wen   = 1'b0;
    ram.wadr  = 8'h00;
    ram.wdata = 8'h00;

    case (state_q)
      S_IDLE: begin
        // stop has priority, so start&stop together keeps the core parked.
        if (start_i && !stop_i) begin
          state_d = S_FA;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      S_FA: begin
        state_d = S_FB;
      end
      S_FB: begin
        a_d      = ram.rdata;
        ram.radr = pc_q + 8'd1;
        state_d  = S_FC;
      end
      S_FC: begin
        b_d      = ram.rdata;
        ram.radr = pc_q + 8'd2;
        state_d  = S_FM;
      end
      S_FM: begin
        c_d      = ram.rdata;
        ram.radr = a_q;
        state_d  = S_FN;
      end
      S_FN: begin
        ma_d     = ram.rdata;
        ram.radr = b_q;
        state_d  = S_WB;
      end
      S_WB: begin
        // The write lands on this edge; the following FA re-reads memory,
        // so self-modifying code sees fresh data without forwarding.
        ram.wen   = 1'b1;
        ram.wadr  = b_q;
        ram.wdata = res;
        pc_d      = taken ? c_q : pc_q + 8'd3;
        cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
        if (taken && (c_q == HALT_ADR)) begin
          state_d = S_HALT;
        end else if (stop_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FA;
        end
      end
      S_HALT: begin
        if (start_i) begin
          state_d = S_FA;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc_o       = pc_q;
  assign busy_o     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted_o   = (state_q == S_HALT);
  assign inst_cnt_o = cnt_q;

endmodule

// File: tb/tb_subleq_core.sv
// tb_subleq_core
//  Directed bench for subleq_core. A behavioural RAM sits on the slave side
//  of the interface; an instruction-level SUBLEQ model on a shadow memory
//  predicts each write-back and pushes it into a scoreboard queue, which is
//  popped when the core pulses the write enable.
module tb_subleq_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [7:0]  pcObs;
  logic        busy;
  logic        halted;
  logic [15:0] instCnt;

  always #5 clk = ~clk;

  subleq_core_if ramIf();

  subleq_core #(
    .START_PC(8'h00),
    .HALT_ADR(8'hFF),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start),
    .stop_i(stop),
    .ram(ramIf),
    .pc_o(pcObs),
    .busy_o(busy),
    .halted_o(halted),
    .inst_cnt_o(instCnt)
  );

  // Behavioural 1r1w RAM with one-cycle read latency; loads go through the
  // same process so memory has a single writer.
  logic [7:0] mem [256];
  logic       loadEn;
  logic [7:0] loadAdr;
  logic [7:0] loadDat;

  always @(posedge clk) begin
    ramIf.rdata <= mem[ramIf.radr];
    if (ramIf.wen) mem[ramIf.wadr] <= ramIf.wdata;
    else if (loadEn) mem[loadAdr] <= loadDat;
  end

  typedef struct {
    logic [7:0]  wadr;
    logic [7:0]  wdata;
    logic [7:0]  pc;
    logic [15:0] cnt;
    logic        halt;
  } expT;

  expT         sb[$];
  logic [7:0]  refMem [256];
  logic [7:0]  refPc;
  logic [15:0] refCnt;
  int          compared = 0;
  int          mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic loadMem(input logic [7:0] adr, input logic [7:0] dat);
    loadEn  = 1'b1;
    loadAdr = adr;
    loadDat = dat;
    refMem[adr] = dat;
    @(posedge clk);
    #1 loadEn = 1'b0;
  endtask

  task automatic loadProg(input logic [7:0] base, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] adr;
    adr = base;
    loadMem(adr, a);
    adr = adr + 8'd1;
    loadMem(adr, b);
    adr = adr + 8'd1;
    loadMem(adr, c);
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    stop   = 1'b0;
    start  = 1'b1;
    refPc  = 8'h00;
    refCnt = 16'h0000;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Instruction-level reference: one SUBLEQ on the shadow memory.
  task automatic modelStep();
    logic [7:0] p1, p2, aA, bA, cA, res;
    logic       tk;
    expT        e;
    p1  = refPc + 8'd1;
    p2  = refPc + 8'd2;
    aA  = refMem[refPc];
    bA  = refMem[p1];
    cA  = refMem[p2];
    res = refMem[bA] - refMem[aA];
    refMem[bA] = res;
    tk  = ($signed(res) <= 8'sd0);
    e.wadr  = bA;
    e.wdata = res;
    e.pc    = tk ? cA : (refPc + 8'd3);
    e.halt  = tk && (cA == 8'hFF);
    e.cnt   = (refCnt == 16'hFFFF) ? refCnt : refCnt + 16'd1;
    refPc   = e.pc;
    refCnt  = e.cnt;
    sb.push_back(e);
  endtask

  // Runs one instruction; stopAt > 0 raises stop on that cycle of it.
  task automatic execInstr(input int stopAt);
    int  cycles;
    expT e;
    modelStep();
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == stopAt) stop = 1'b1;
    end while (!ramIf.wen && cycles < 20);
    checkOutput("latency", cycles, 6);
    e = sb.pop_front();
    checkOutput("wadr", ramIf.wadr, e.wadr);
    checkOutput("wdata", ramIf.wdata, e.wdata);
    @(posedge clk);
    #1;
    checkOutput("pc", pcObs, e.pc);
    checkOutput("inst_cnt", instCnt, e.cnt);
    checkOutput("halted", halted, e.halt);
    checkOutput("busy", busy, !(e.halt || stop));
  endtask

  initial begin
    int cycles;
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    loadEn = 1'b0;
    refPc  = 8'h00;
    refCnt = 16'h0000;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pc", pcObs, 8'h00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_cnt", instCnt, 16'h0000);
    checkOutput("rst_wen", ramIf.wen, 1'b0);
    checkOutput("rst_wadr", ramIf.wadr, 8'h00);
    checkOutput("rst_wdata", ramIf.wdata, 8'h00);
    for (int i = 0; i < 256; i++) loadMem(8'(i), 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] T1 basic non-branching instruction");
    loadProg(8'h00, 8'd10, 8'd11, 8'd3);
    loadMem(8'd10, 8'd2);
    loadMem(8'd11, 8'd5);
    applyStimulus();
    execInstr(1);
    checkOutput("t1_mem11", mem[11], 8'd3);

    $display("[TB] T2 zero and negative results branch");
    loadProg(8'h00, 8'd10, 8'd11, 8'd40);
    loadMem(8'd10, 8'd5);
    loadMem(8'd11, 8'd5);
    applyStimulus();
    execInstr(1);
    loadMem(8'd10, 8'd6);
    loadMem(8'd11, 8'd5);
    applyStimulus();
    execInstr(1);
    checkOutput("t2_mem11", mem[11], 8'hFF);

    $display("[TB] T3 halt and restart");
    loadProg(8'h00, 8'd10, 8'd11, 8'd3);
    loadMem(8'd10, 8'd2);
    loadMem(8'd11, 8'd5);
    loadProg(8'h03, 8'd20, 8'd20, 8'hFF);
    loadMem(8'd20, 8'd7);
    applyStimulus();
    execInstr(0);
    execInstr(0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t3_hold_pc", pcObs, 8'hFF);
    checkOutput("t3_hold_cnt", instCnt, 16'd2);
    checkOutput("t3_hold_halted", halted, 1'b1);
    checkOutput("t3_hold_busy", busy, 1'b0);
    applyStimulus();
    checkOutput("t3_restart_pc", pcObs, 8'h00);
    checkOutput("t3_restart_busy", busy, 1'b1);
    execInstr(1);

    $display("[TB] T4 operand fetch wraps at FE");
    loadProg(8'h00, 8'd30, 8'd30, 8'hFE);
    loadMem(8'd30, 8'd5);
    loadMem(8'hFE, 8'd12);
    loadMem(8'hFF, 8'd13);
    loadMem(8'd12, 8'd1);
    loadMem(8'd13, 8'd9);
    applyStimulus();
    execInstr(0);
    execInstr(1);
    checkOutput("t4_pc_wrap", pcObs, 8'h01);

    $display("[TB] T5 self-modifying code");
    loadProg(8'h00, 8'd10, 8'd3, 8'd50);
    loadMem(8'd10, 8'd4);
    loadProg(8'h03, 8'd20, 8'd17, 8'd60);
    loadMem(8'd16, 8'd1);
    loadMem(8'd17, 8'd7);
    loadMem(8'd20, 8'd3);
    applyStimulus();
    execInstr(0);
    execInstr(1);
    checkOutput("t5_mem17", mem[17], 8'd6);

    $display("[TB] T6 stop in FC, start+stop, reset in WB");
    loadProg(8'h00, 8'd10, 8'd11, 8'd3);
    loadMem(8'd10, 8'd2);
    loadMem(8'd11, 8'd5);
    applyStimulus();
    execInstr(3);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_idle_busy", busy, 1'b0);
    checkOutput("t6_idle_pc", pcObs, 8'd3);
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("t6_startstop_busy", busy, 1'b0);
    applyStimulus();
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!ramIf.wen && cycles < 20);
    checkOutput("t6_rst_latency", cycles, 6);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_wen", ramIf.wen, 1'b0);
    checkOutput("t6_rst_wadr", ramIf.wadr, 8'h00);
    checkOutput("t6_rst_busy", busy, 1'b0);
    checkOutput("t6_rst_pc", pcObs, 8'h00);
    checkOutput("t6_rst_cnt", instCnt, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    checkOutput("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
